// File: rtl/fp_to_int.sv
// fp_to_int: multi-cycle IEEE-754 single to int32 converter; FP_ROUND_NEAREST_EN selects round-to-nearest-even, otherwise truncate
module fp_to_int (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        overflow,
  output logic        invalid
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  state_t      r_state, w_next;
  logic        r_sign, r_left, r_guard, r_sticky;
  logic [31:0] r_mag;
  logic [7:0]  r_n;
  logic [7:0]  w_exp, w_n;
  logic        w_nan, w_small, w_big, w_left, w_inc, w_ovf;
  logic [32:0] w_rnd;
  logic [31:0] w_res;
  assign w_exp   = a[30:23];
  assign w_nan   = (&w_exp) & (|a[22:0]);
  assign w_small = w_exp < 8'd126;
  assign w_big   = w_exp >= 8'd158;
  assign w_left  = w_exp >= 8'd150;
  assign w_n     = w_left ? w_exp - 8'd150 : 8'd150 - w_exp;
`ifdef FP_ROUND_NEAREST_EN
  assign w_inc = r_guard & (r_sticky | r_mag[0]);
`else
  // guard/sticky are still tracked so both builds share one datapath; truncation discards them
  assign w_inc = 1'b0 & r_guard & (r_sticky | r_mag[0]);
`endif
  assign w_rnd = {1'b0, r_mag} + {32'd0, w_inc};
  assign w_ovf = r_sign ? (w_rnd > 33'h080000000) : (w_rnd > 33'h07FFFFFFF);
  assign w_res = w_ovf ? (r_sign ? 32'h80000000 : 32'h7FFFFFFF)
                       : (r_sign ? 32'd0 - w_rnd[31:0] : w_rnd[31:0]);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: exceptional operands skip straight to DONE; SHIFT leaves on the cycle its count reaches zero
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = !start ? IDLE : (w_nan | w_small | w_big) ? DONE : (w_n != 8'd0) ? SHIFT : ROUND;
    else if (r_state == SHIFT)
      w_next = (r_n == 8'd1) ? ROUND : SHIFT;
    else if (r_state == ROUND)
      w_next = DONE;
    else
      w_next = IDLE;
  end
  // status outputs decoded from state
  always_comb begin
    busy = r_state != IDLE;
    done = r_state == DONE;
  end
  // operand capture, serial shifter and result/flag registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_left   <= 1'b0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_mag    <= 32'd0;
      r_n      <= 8'd0;
      result   <= 32'd0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sign   <= a[31];
      r_left   <= w_left;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_mag    <= {8'd0, 1'b1, a[22:0]};
      r_n      <= w_n;
      if (w_nan) begin
        result   <= 32'h80000000;
        zero     <= 1'b0;
        overflow <= 1'b0;
        invalid  <= 1'b1;
      end else if (w_small) begin
        result   <= 32'd0;
        zero     <= 1'b1;
        overflow <= 1'b0;
        invalid  <= 1'b0;
      end else if (w_big) begin
        result   <= a[31] ? 32'h80000000 : 32'h7FFFFFFF;
        zero     <= 1'b0;
        overflow <= a != 32'hCF000000;
        invalid  <= 1'b0;
      end
    end else if (r_state == SHIFT) begin
      r_n      <= r_n - 8'd1;
      r_mag    <= r_left ? r_mag << 1 : r_mag >> 1;
      r_guard  <= r_left ? r_guard : r_mag[0];
      r_sticky <= r_left ? r_sticky : r_sticky | r_guard;
    end else if (r_state == ROUND) begin
      result   <= w_res;
      zero     <= w_res == 32'd0;
      overflow <= w_ovf;
      invalid  <= 1'b0;
    end
endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: vector table, directed corner sequences and random operands against a real-arithmetic model
module tb_fp_to_int;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] result;
  logic        busy, done, zero, overflow, invalid;
  int          n_chk = 0, n_fail = 0;

  fp_to_int dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .result(result),
                 .busy(busy), .done(done), .zero(zero), .overflow(overflow), .invalid(invalid));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    bit          ovf;
    bit          inv;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] v);
    vec_t r;
    int   e;
    real  mag, fl;
    longint q;
    e = int'(v[30:23]);
    r.a = v; r.ovf = 0; r.inv = 0; r.lat = 1;
    if (e == 255 && v[22:0] != 0) begin r.res = 32'h80000000; r.inv = 1; return r; end
    if (e < 126) begin r.res = 32'd0; return r; end
    if (e >= 158) begin
      r.res = v[31] ? 32'h80000000 : 32'h7FFFFFFF;
      r.ovf = (v != 32'hCF000000);
      return r;
    end
    mag = 1.0 + real'(v[22:0]) / 8388608.0;
    for (int k = 127; k < e; k++) mag = mag * 2.0;
    for (int k = e; k < 127; k++) mag = mag / 2.0;
    fl = $floor(mag);
`ifdef FP_ROUND_NEAREST_EN
    if (mag - fl > 0.5 || (mag - fl == 0.5 && (longint'(fl) % 2) == 1)) fl = fl + 1.0;
`endif
    q = longint'(fl);
    r.lat = (e >= 150 ? e - 150 : 150 - e) + 2;
    if (!v[31] && q > 64'sd2147483647) begin r.res = 32'h7FFFFFFF; r.ovf = 1; return r; end
    if (v[31] && q > 64'sd2147483648) begin r.res = 32'h80000000; r.ovf = 1; return r; end
    q = v[31] ? -q : q;
    r.res = q[31:0];
    return r;
  endfunction

  task automatic run(input logic [31:0] v, output logic [31:0] res, output logic ov,
                     output logic inv, output logic zr, output int lat);
    @(negedge clk);
    a = v; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 100);
    res = result; ov = overflow; inv = invalid; zr = zero;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("result_hold", result, res);
  endtask

  task automatic check_vec(input string nm, input vec_t x);
    logic [31:0] res;
    logic        ov, inv, zr;
    int          lat;
    run(x.a, res, ov, inv, zr, lat);
    chk({nm, "_result"}, res, x.res);
    chk({nm, "_overflow"}, {31'd0, ov}, {31'd0, x.ovf});
    chk({nm, "_invalid"}, {31'd0, inv}, {31'd0, x.inv});
    chk({nm, "_zero"}, {31'd0, zr}, {31'd0, x.res == 32'd0});
    chk({nm, "_latency"}, lat, x.lat);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t x;
    logic [31:0] v;
    int lat, cnt;
`ifdef FP_ROUND_NEAREST_EN
    localparam bit NEAR = 1'b1;
`else
    localparam bit NEAR = 1'b0;
`endif
    tbl.push_back('{32'h42FF0000, NEAR ? 32'd128 : 32'd127, 0, 0, 19});
    tbl.push_back('{32'h3F19999A, NEAR ? 32'd1 : 32'd0, 0, 0, 26});
    tbl.push_back('{32'hC0600000, NEAR ? 32'hFFFFFFFC : 32'hFFFFFFFD, 0, 0, 24});
    tbl.push_back('{32'h40200000, 32'd2, 0, 0, 24});
    tbl.push_back('{32'h3FC00000, NEAR ? 32'd2 : 32'd1, 0, 0, 25});
    tbl.push_back('{32'h3F000000, 32'd0, 0, 0, 26});
    tbl.push_back('{32'h00000000, 32'd0, 0, 0, 1});
    tbl.push_back('{32'h80000000, 32'd0, 0, 0, 1});
    tbl.push_back('{32'h3EFFFFFF, 32'd0, 0, 0, 1});
    tbl.push_back('{32'h7FC00000, 32'h80000000, 0, 1, 1});
    tbl.push_back('{32'h7F800001, 32'h80000000, 0, 1, 1});
    tbl.push_back('{32'h7F800000, 32'h7FFFFFFF, 1, 0, 1});
    tbl.push_back('{32'hFF800000, 32'h80000000, 1, 0, 1});
    tbl.push_back('{32'hCF000000, 32'h80000000, 0, 0, 1});
    tbl.push_back('{32'h4F000000, 32'h7FFFFFFF, 1, 0, 1});
    tbl.push_back('{32'hCF800000, 32'h80000000, 1, 0, 1});
    tbl.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 0, 0, 9});
    tbl.push_back('{32'h4B000001, 32'd8388609, 0, 0, 2});

    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {26'd0, busy, done, zero, overflow, invalid, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) check_vec($sformatf("vec%0d_%h", i, tbl[i].a), tbl[i]);

    // second start three cycles into a conversion is dropped
    @(negedge clk);
    a = 32'h42FF0000; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == 3);
      if (lat == 3) a = 32'h3F800000;
    end while (!done && lat < 100);
    chk("busy_start_latency", lat, 19);
    chk("busy_start_result", result, NEAR ? 32'd128 : 32'd127);
    start = 1'b0;

    // start held through DONE is only accepted once back in IDLE
    @(negedge clk);
    a = 32'h40000000; start = 1'b1; lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 100);
    chk("held_start_latency", lat, 24);
    @(negedge clk);
    chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_after_done_taken", {31'd0, busy}, 32'd1);
    start = 1'b0; lat = 1;
    do begin @(negedge clk); lat++; end while (!done && lat < 100);
    chk("held_start_second_latency", lat, 24);
    chk("held_start_second_result", result, 32'd2);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    a = 32'h42FF0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_shift_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {27'd0, busy, done, zero, overflow, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (30) begin @(negedge clk); cnt += int'(done) + int'(busy); end
    chk("abort_no_done", cnt, 0);
    check_vec("after_reset", tbl[1]);

    for (int i = 0; i < 200; i++) begin
      v = $urandom;
      if (i % 4 != 0) v[30:23] = 8'($urandom_range(120, 160));
      x = model(v);
      check_vec($sformatf("rand_%h", v), x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 The block SHALL have no parameters; operand and result widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  32  IEEE-754 single operand; sampled with start.
REQ-006 result  output  32  signed two's-complement integer.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; result and flags valid that cycle.
REQ-009 zero  output  1  result == 0.
REQ-010 overflow  output  1  magnitude out of int32 range, or infinity.
REQ-011 invalid  output  1  operand is NaN.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, ROUND and DONE.
REQ-013 IDLE with start=1 SHALL latch sign, exponent e and 24-bit significand (hidden 1) in one cycle.
REQ-014 Shift count SHALL be n=|e-150|: left shifts if e>=150, right shifts otherwise.
REQ-015 The start edge SHALL go to SHIFT if n>0, else to ROUND.
REQ-016 SHIFT SHALL shift one bit per cycle and decrement n; at n==0 it SHALL go to ROUND.
REQ-017 Right shifts SHALL keep guard bit = last bit shifted out and sticky = OR of all earlier shifted-out bits.
REQ-018 ROUND SHALL apply rounding (REQ-030), apply sign, check range, then go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 Normal operands with 126<=e<=157 SHALL have done high n+2 cycles after the start edge.
REQ-021 e<126, including zero and denormals, SHALL go straight to DONE with result 0; done high 1 cycle after start.
REQ-022 e=255 with nonzero fraction SHALL go straight to DONE with result 32'h80000000 and invalid=1.
REQ-023 e>=158 SHALL go straight to DONE with overflow=1.
  - Saturated result: 32'h7FFFFFFF if positive, 32'h80000000 if negative.
  - Exception: operand exactly -2^31 (32'hCF000000) SHALL give 32'h80000000 with overflow=0.
REQ-024 A positive value that rounds up to 2^31 in ROUND SHALL saturate to 32'h7FFFFFFF with overflow=1.
REQ-025 result, zero, overflow and invalid SHALL hold from DONE until the next accepted start.
REQ-026 start while busy=1 SHALL be ignored; there is no queueing.
REQ-027 start in the same cycle as DONE SHALL be ignored; it is accepted the following cycle in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE and clear result, busy, done, zero, overflow and invalid to 0.
REQ-029 Reset during SHIFT or ROUND SHALL abort the conversion with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-030 Macro FP_ROUND_NEAREST_EN SHALL select the rounding mode in ROUND.
  - Defined: round-to-nearest-even; increment the magnitude if guard=1 and (sticky=1 or LSB=1).
  - Undefined: truncate toward zero; guard and sticky are ignored and REQ-024 can never fire.
  - Latency and all other behaviour SHALL be the same in both builds.

Verification
REQ-031 a=32'h42FF0000 (127.5), start pulse -> done 19 cycles later; result 128 if FP_ROUND_NEAREST_EN, else 127; zero=0.
REQ-032 a=32'h3F19999A (0.6) -> result 1 (nearest) or 0 with zero=1 (truncate); a=32'hC0600000 (-3.5) -> -4 (nearest) or -3 (truncate).
REQ-033 a=32'h40200000 (2.5) -> 2 under nearest (tie to even); a=32'h00000000 -> done 1 cycle after start, result 0, zero=1.
REQ-034 Special operands:
  - 32'h7FC00000 -> invalid=1, result 32'h80000000.
  - 32'h7F800000 -> overflow=1, result 32'h7FFFFFFF.
  - 32'hCF000000 -> result 32'h80000000, overflow=0.
REQ-035 Second start with a=32'h3F800000, issued 3 cycles into a 127.5 conversion -> ignored; result 128 (nearest).
REQ-036 rst_n low during SHIFT -> no done pulse, all outputs 0; a fresh start after release completes normally.
